// File: rtl/rgb_pwm_encoder_if.sv
// Bundle between the colour-sequencing decoder (master) and the RGB PWM encoder (slave).
// Handshake: the master may pulse load for one cycle only while busy is low; a load seen
// while busy is high is dropped. busy stays high from the cycle after an accepted load
// until the cycle after the boundary that finishes applying the captured targets.
`timescale 1ns/1ps
interface rgb_pwm_encoder_if;
  logic [7:0] R_time_in;
  logic [7:0] G_time_in;
  logic [7:0] B_time_in;
  logic       load;
  logic       busy;
  logic       pwm_r;
  logic       pwm_g;
  logic       pwm_b;
  logic       period_start;

  modport master (
    output R_time_in, G_time_in, B_time_in, load,
    input  busy, pwm_r, pwm_g, pwm_b, period_start
  );

  modport slave (
    input  R_time_in, G_time_in, B_time_in, load,
    output busy, pwm_r, pwm_g, pwm_b, period_start
  );
endinterface

// File: rtl/rgb_pwm_encoder.sv
// Three-channel 255-tick PWM generator for RGB LEDs. Duty targets are captured on load
// and moved into the active compare registers only at period boundaries, optionally
// ramping by FADE_STEP per period. All outputs are registered.
`timescale 1ns/1ps
module rgb_pwm_encoder #(
  parameter int PRESCALE   = 1,
  parameter int FADE_STEP  = 0,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic               clk_div,
  input  logic               rst,
  rgb_pwm_encoder_if.slave   bus,
  output logic [1:0]         dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    FADING  = 2'd2
  } state_t;

  localparam logic [7:0] PRE_LAST = 8'(PRESCALE - 1);
  localparam logic [7:0] STEP     = 8'(FADE_STEP);

  state_t     state_q, state_d;
  logic [7:0] pre_q, cnt_q;
  logic [7:0] act_r_q, act_g_q, act_b_q;
  logic [7:0] act_r_d, act_g_d, act_b_d;
  logic [7:0] tgt_r_q, tgt_g_q, tgt_b_q;
  logic [7:0] tgt_r_d, tgt_g_d, tgt_b_d;
  logic       busy_q, busy_d;
  logic       wrap_q, period_start_q;
  logic       pwm_r_q, pwm_g_q, pwm_b_q;
  logic       tick, boundary;

  assign tick     = (pre_q == PRE_LAST);
  assign boundary = tick && (cnt_q == 8'd254);

  // One ramp step of a channel toward its target; the difference is taken without wrap.
  function automatic logic [7:0] step_to(input logic [7:0] act, input logic [7:0] tgt);
    logic [8:0] diff;
    diff    = 9'd0;
    step_to = tgt;
    if (FADE_STEP != 0) begin
      if (act < tgt) diff = {1'b0, tgt} - {1'b0, act};
      else           diff = {1'b0, act} - {1'b0, tgt};
      if (diff <= {1'b0, STEP}) step_to = tgt;
      else if (act < tgt)       step_to = act + STEP;
      else                      step_to = act - STEP;
    end
  endfunction

  // Prescaler and 0..254 period counter.
  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) begin
      pre_q <= 8'd0;
      cnt_q <= 8'd0;
    end else begin
      pre_q <= tick ? 8'd0 : pre_q + 8'd1;
      if (tick) cnt_q <= boundary ? 8'd0 : cnt_q + 8'd1;
    end
  end

  // Next-state logic: capture targets when idle, update active duties at boundaries.
  // In IDLE act already equals tgt, so skipping the boundary update there is exact.
  always_comb begin
    state_d = state_q;
    tgt_r_d = tgt_r_q;
    tgt_g_d = tgt_g_q;
    tgt_b_d = tgt_b_q;
    act_r_d = act_r_q;
    act_g_d = act_g_q;
    act_b_d = act_b_q;
    case (state_q)
      IDLE: begin
        if (bus.load) begin
          tgt_r_d = bus.R_time_in;
          tgt_g_d = bus.G_time_in;
          tgt_b_d = bus.B_time_in;
          state_d = PENDING;
        end
      end
      PENDING, FADING: begin
        if (boundary) begin
          act_r_d = step_to(act_r_q, tgt_r_q);
          act_g_d = step_to(act_g_q, tgt_g_q);
          act_b_d = step_to(act_b_q, tgt_b_q);
          if ((act_r_d == tgt_r_q) && (act_g_d == tgt_g_q) && (act_b_d == tgt_b_q))
            state_d = IDLE;
          else
            state_d = FADING;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // FSM, duty and busy registers.
  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tgt_r_q <= 8'd0;
      tgt_g_q <= 8'd0;
      tgt_b_q <= 8'd0;
      act_r_q <= 8'd0;
      act_g_q <= 8'd0;
      act_b_q <= 8'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_r_q <= tgt_r_d;
      tgt_g_q <= tgt_g_d;
      tgt_b_q <= tgt_b_d;
      act_r_q <= act_r_d;
      act_g_q <= act_g_d;
      act_b_q <= act_b_d;
      busy_q  <= busy_d;
    end
  end

  // Registered compare outputs; period_start is delayed so it lines up with the
  // first PWM sample taken from cnt==0 with the freshly updated duties.
  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) begin
      pwm_r_q        <= ACTIVE_LOW;
      pwm_g_q        <= ACTIVE_LOW;
      pwm_b_q        <= ACTIVE_LOW;
      wrap_q         <= 1'b0;
      period_start_q <= 1'b0;
    end else begin
      pwm_r_q        <= (cnt_q < act_r_q) ^ ACTIVE_LOW;
      pwm_g_q        <= (cnt_q < act_g_q) ^ ACTIVE_LOW;
      pwm_b_q        <= (cnt_q < act_b_q) ^ ACTIVE_LOW;
      wrap_q         <= boundary;
      period_start_q <= wrap_q;
    end
  end

  assign bus.busy         = busy_q;
  assign bus.pwm_r        = pwm_r_q;
  assign bus.pwm_g        = pwm_g_q;
  assign bus.pwm_b        = pwm_b_q;
  assign bus.period_start = period_start_q;
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_rgb_pwm_encoder.sv
// Directed bench for rgb_pwm_encoder: three instances cover the default, fading and
// prescaled/active-low configurations. Outputs are sampled on the falling edge.
`timescale 1ns/1ps
module tb_rgb_pwm_encoder;

  logic clk_div = 1'b0;
  logic rst     = 1'b1;
  always #5 clk_div = ~clk_div;

  rgb_pwm_encoder_if if0();
  rgb_pwm_encoder_if if1();
  rgb_pwm_encoder_if if2();
  logic [1:0] st0, st1, st2;

  rgb_pwm_encoder #(.PRESCALE(1), .FADE_STEP(0),  .ACTIVE_LOW(1'b0)) dut0 (
    .clk_div(clk_div), .rst(rst), .bus(if0), .dbg_state_o(st0));
  rgb_pwm_encoder #(.PRESCALE(1), .FADE_STEP(64), .ACTIVE_LOW(1'b0)) dut1 (
    .clk_div(clk_div), .rst(rst), .bus(if1), .dbg_state_o(st1));
  rgb_pwm_encoder #(.PRESCALE(4), .FADE_STEP(0),  .ACTIVE_LOW(1'b1)) dut2 (
    .clk_div(clk_div), .rst(rst), .bus(if2), .dbg_state_o(st2));

  int checks = 0;
  int errors = 0;

  // ---------------- driver tasks ----------------
  task automatic drive(input int d, input logic ld, input logic [7:0] r, g, b);
    case (d)
      0: begin if0.load = ld; if0.R_time_in = r; if0.G_time_in = g; if0.B_time_in = b; end
      1: begin if1.load = ld; if1.R_time_in = r; if1.G_time_in = g; if1.B_time_in = b; end
      default: begin if2.load = ld; if2.R_time_in = r; if2.G_time_in = g; if2.B_time_in = b; end
    endcase
  endtask

  // {busy, period_start, pwm_r, pwm_g, pwm_b}
  function automatic logic [4:0] obs(input int d);
    case (d)
      0: obs = {if0.busy, if0.period_start, if0.pwm_r, if0.pwm_g, if0.pwm_b};
      1: obs = {if1.busy, if1.period_start, if1.pwm_r, if1.pwm_g, if1.pwm_b};
      default: obs = {if2.busy, if2.period_start, if2.pwm_r, if2.pwm_g, if2.pwm_b};
    endcase
  endfunction

  // Leaves rst released on a falling edge; the next rising edge is the first after reset.
  task automatic do_reset();
    rst = 1'b1;
    for (int d = 0; d < 3; d++) drive(d, 1'b0, 8'd0, 8'd0, 8'd0);
    repeat (3) @(negedge clk_div);
    rst = 1'b0;
  endtask

  // One-cycle load pulse; returns at the falling edge after the load was sampled.
  task automatic load_rgb(input int d, input logic [7:0] r, g, b);
    @(negedge clk_div);
    drive(d, 1'b1, r, g, b);
    @(negedge clk_div);
    drive(d, 1'b0, r, g, b);
  endtask

  task automatic wait_ps(input int d, input int budget, output bit ok);
    logic [4:0] s;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_div);
      s = obs(d);
      if (s[3]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Called on a period_start sample; samples one full period and the sample after it.
  task automatic measure(input int d, input int len, output int on_r, output int on_g,
                         output int on_b, output int runs_r, output int runs_g,
                         output bit next_ps);
    logic [4:0] s;
    logic pr, pg;
    on_r = 0; on_g = 0; on_b = 0; runs_r = 0; runs_g = 0;
    pr = 1'b0; pg = 1'b0;
    for (int i = 0; i < len; i++) begin
      if (i > 0) @(negedge clk_div);
      s = obs(d);
      if (s[2]) on_r++;
      if (s[1]) on_g++;
      if (s[0]) on_b++;
      if (s[2] && !pr) runs_r++;
      if (s[1] && !pg) runs_g++;
      pr = s[2];
      pg = s[1];
    end
    @(negedge clk_div);
    s = obs(d);
    next_ps = s[3];
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [4:0] s;
    int ps_cnt, first_ps, last_ps, bad_gap;
    bit saw_pwm, saw_busy;
    do_reset();
    s = obs(0);
    checks++;
    if (s !== 5'b00000) begin
      errors++; $display("FAIL reset_dut0 got %b exp 00000", s);
    end
    s = obs(2);
    checks++;
    if (s !== 5'b00111) begin
      errors++; $display("FAIL reset_dut2_active_low got %b exp 00111", s);
    end
    checks++;
    if (st0 !== 2'd0) begin
      errors++; $display("FAIL reset_state got %0d exp 0", st0);
    end
    ps_cnt = 0; first_ps = -1; last_ps = -1; bad_gap = 0; saw_pwm = 0; saw_busy = 0;
    for (int i = 1; i <= 2000; i++) begin
      @(negedge clk_div);
      s = obs(0);
      if (s[2] || s[1] || s[0]) saw_pwm = 1'b1;
      if (s[4]) saw_busy = 1'b1;
      if (s[3]) begin
        if (first_ps < 0) first_ps = i;
        else if (i - last_ps != 255) bad_gap++;
        last_ps = i;
        ps_cnt++;
      end
    end
    checks++;
    if (saw_pwm !== 1'b0) begin
      errors++; $display("FAIL idle_pwm got high exp low");
    end
    checks++;
    if (saw_busy !== 1'b0) begin
      errors++; $display("FAIL idle_busy got high exp low");
    end
    checks++;
    if (first_ps != 256) begin
      errors++; $display("FAIL first_period_start got cycle %0d exp 256", first_ps);
    end
    checks++;
    if (ps_cnt != 7 || bad_gap != 0) begin
      errors++; $display("FAIL period_start_spacing got %0d pulses %0d bad gaps exp 7 0",
                         ps_cnt, bad_gap);
    end
  endtask

  task automatic test_immediate_load();
    logic [4:0] s;
    bit ok, nps;
    int on_r, on_g, on_b, runs_r, runs_g;
    do_reset();
    load_rgb(0, 8'd128, 8'd0, 8'd255);
    s = obs(0);
    checks++;
    if (s[4] !== 1'b1) begin
      errors++; $display("FAIL imm_busy_rise got %b exp 1", s[4]);
    end
    wait_ps(0, 300, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL imm_timeout got no period_start exp one within 300");
      return;
    end
    s = obs(0);
    checks++;
    if (s[4] !== 1'b0) begin
      errors++; $display("FAIL imm_busy_fall got %b exp 0", s[4]);
    end
    for (int p = 0; p < 2; p++) begin
      measure(0, 255, on_r, on_g, on_b, runs_r, runs_g, nps);
      checks++;
      if (on_r != 128 || runs_r != 1) begin
        errors++; $display("FAIL imm_r got %0d on %0d runs exp 128 1", on_r, runs_r);
      end
      checks++;
      if (on_g != 0 || on_b != 255) begin
        errors++; $display("FAIL imm_gb got %0d/%0d exp 0/255", on_g, on_b);
      end
      checks++;
      if (nps !== 1'b1) begin
        errors++; $display("FAIL imm_period_len got ps=%b exp 1 after 255", nps);
        return;
      end
    end
  endtask

  task automatic test_load_while_busy();
    logic [4:0] s;
    bit ok, nps;
    int on_r, on_g, on_b, runs_r, runs_g;
    do_reset();
    @(negedge clk_div);
    drive(0, 1'b1, 8'd10, 8'd0, 8'd0);
    @(negedge clk_div);
    s = obs(0);
    checks++;
    if (s[4] !== 1'b1) begin
      errors++; $display("FAIL lwb_busy got %b exp 1", s[4]);
    end
    drive(0, 1'b1, 8'd200, 8'd0, 8'd0);
    @(negedge clk_div);
    drive(0, 1'b0, 8'd0, 8'd0, 8'd0);
    wait_ps(0, 300, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL lwb_timeout got no period_start exp one within 300");
      return;
    end
    for (int p = 0; p < 2; p++) begin
      measure(0, 255, on_r, on_g, on_b, runs_r, runs_g, nps);
      checks++;
      if (on_r != 10) begin
        errors++; $display("FAIL lwb_r_period%0d got %0d exp 10", p, on_r);
      end
      if (!nps) begin
        checks++; errors++;
        $display("FAIL lwb_period_len got ps=0 exp 1");
        return;
      end
    end
  endtask

  task automatic test_fade();
    logic [4:0] s;
    bit ok, nps;
    int on_r, on_g, on_b, runs_r, runs_g;
    int up_exp[4]   = '{64, 128, 192, 255};
    int down_exp[4] = '{191, 127, 63, 0};
    bit busy_exp[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    for (int dir = 0; dir < 2; dir++) begin
      load_rgb(1, (dir == 0) ? 8'd255 : 8'd0, 8'd0, 8'd0);
      wait_ps(1, 300, ok);
      checks++;
      if (!ok) begin
        errors++; $display("FAIL fade_timeout got no period_start exp one within 300");
        return;
      end
      for (int p = 0; p < 4; p++) begin
        s = obs(1);
        checks++;
        if (s[4] !== busy_exp[p]) begin
          errors++; $display("FAIL fade_busy dir%0d p%0d got %b exp %b", dir, p, s[4], busy_exp[p]);
        end
        measure(1, 255, on_r, on_g, on_b, runs_r, runs_g, nps);
        checks++;
        if (on_r != ((dir == 0) ? up_exp[p] : down_exp[p])) begin
          errors++; $display("FAIL fade_r dir%0d p%0d got %0d exp %0d", dir, p, on_r,
                             (dir == 0) ? up_exp[p] : down_exp[p]);
        end
        if (!nps) begin
          checks++; errors++;
          $display("FAIL fade_period_len got ps=0 exp 1");
          return;
        end
      end
    end
  endtask

  task automatic test_reset_mid_fade();
    logic [4:0] s;
    bit ok, nps;
    int on_r, on_g, on_b, runs_r, runs_g;
    do_reset();
    load_rgb(1, 8'd255, 8'd0, 8'd0);
    wait_ps(1, 300, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL rmf_timeout got no period_start exp one within 300");
      return;
    end
    measure(1, 255, on_r, on_g, on_b, runs_r, runs_g, nps);
    repeat (100) @(negedge clk_div);
    s = obs(1);
    checks++;
    if (s[2] !== 1'b1 || s[4] !== 1'b1) begin
      errors++; $display("FAIL rmf_pre_reset got r=%b busy=%b exp 1 1", s[2], s[4]);
    end
    #1 rst = 1'b1;
    #1 s = obs(1);
    checks++;
    if (s !== 5'b00000 || st1 !== 2'd0) begin
      errors++; $display("FAIL rmf_async_reset got %b st=%0d exp 00000 st=0", s, st1);
    end
    @(negedge clk_div);
    rst = 1'b0;
    load_rgb(1, 8'd30, 8'd0, 8'd0);
    wait_ps(1, 300, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL rmf_reload_timeout got no period_start exp one within 300");
      return;
    end
    s = obs(1);
    checks++;
    if (s[4] !== 1'b0) begin
      errors++; $display("FAIL rmf_busy got %b exp 0", s[4]);
    end
    measure(1, 255, on_r, on_g, on_b, runs_r, runs_g, nps);
    checks++;
    if (on_r != 30 || runs_r != 1) begin
      errors++; $display("FAIL rmf_r got %0d on %0d runs exp 30 1", on_r, runs_r);
    end
  endtask

  task automatic test_prescale_polarity();
    bit ok, nps;
    int on_r, on_g, on_b, runs_r, runs_g;
    do_reset();
    load_rgb(2, 8'd0, 8'd50, 8'd0);
    wait_ps(2, 2200, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL pre_timeout got no period_start exp one within 2200");
      return;
    end
    measure(2, 1020, on_r, on_g, on_b, runs_r, runs_g, nps);
    checks++;
    if (on_g != 820 || runs_g != 1) begin
      errors++; $display("FAIL pre_g got %0d high %0d runs exp 820 1", on_g, runs_g);
    end
    checks++;
    if (on_r != 1020 || on_b != 1020) begin
      errors++; $display("FAIL pre_rb got %0d/%0d exp 1020/1020", on_r, on_b);
    end
    checks++;
    if (nps !== 1'b1) begin
      errors++; $display("FAIL pre_period_len got ps=%b exp 1 after 1020", nps);
    end
  endtask

  initial begin
    test_reset();
    test_immediate_load();
    test_load_while_busy();
    test_fade();
    test_reset_mid_fade();
    test_prescale_polarity();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rgb_pwm_encoder.md
# rgb_pwm_encoder

Converts the 8-bit R/G/B duty values produced by the colour-sequencing decoder into three PWM waveforms for the RGB LED pins. It sits downstream of the decoder and runs on the divided clock `clk_div`. New duty values are captured on a load strobe and applied only at PWM period boundaries, so the LED never sees a glitch. An optional per-period fade ramps each channel toward its new target.

## Interface
- `PRESCALE`, default 1: number of `clk_div` cycles per PWM tick. Legal range is 1..255.
- `FADE_STEP`, default 0: maximum change in duty per channel per PWM period. A value of 0 means the new duty is applied immediately at the next boundary. Legal range is 0..255.
- `ACTIVE_LOW`, default 0: when set to 1, all three PWM outputs are inverted, for common-anode LEDs.
- `clk_div` in 1: block clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `R_time_in` in 8: red duty target, 0..255.
- `G_time_in` in 8: green duty target.
- `B_time_in` in 8: blue duty target.
- `load` in 1: single-cycle strobe that captures the three targets.
- `busy` out 1: high while captured targets are not yet fully applied.
- `pwm_r` out 1: red PWM waveform.
- `pwm_g` out 1: green PWM waveform.
- `pwm_b` out 1: blue PWM waveform.
- `period_start` out 1: one-cycle pulse marking the first cycle of each PWM period.

## Operation
- **Prescaler:** `pre` counts 0..PRESCALE-1 and wraps. A tick occurs in the cycle where `pre == PRESCALE-1`.
- **Period counter:** `cnt` is 8 bits, advances by one on each tick, and counts 0..254. When `cnt == 254` on a tick it wraps to 0. One period is 255 ticks.
- **Boundary:** a boundary is the tick on which `cnt` wraps from 254 to 0.
- **Active duty registers:** `act_r`, `act_g`, `act_b` change only at a boundary.
- **Target registers:** `tgt_r`, `tgt_g`, `tgt_b`.
- **Compare:** each PWM channel is on when `cnt < act_x`. Consequences:
  - duty 0 is always off;
  - duty 255 is always on;
  - duty N is on for N ticks per period.
- **Output polarity:** output level is the compare result XOR `ACTIVE_LOW`.
- **FSM states:**
  - IDLE: `busy=0`.
  - PENDING: `busy=1`, targets captured, waiting for a boundary.
  - FADING: `busy=1`, ramp in progress.
- **FSM transitions:**
  - IDLE → PENDING on `load=1`. Targets are captured in the same cycle.
  - PENDING → at a boundary, the active registers are updated (see update rule). The FSM then goes to IDLE if `act == tgt` on all channels, otherwise to FADING.
  - FADING → at each boundary, the active registers are updated again. The FSM goes to IDLE once all channels equal their targets.
- **Update rule:**
  - If `FADE_STEP == 0`: `act = tgt`.
  - Otherwise, for each channel, with the difference computed as 9-bit unsigned (no wrap):
    - if `|tgt - act| <= FADE_STEP`: `act = tgt`;
    - if `act < tgt` otherwise: `act += FADE_STEP`;
    - if `act > tgt` otherwise: `act -= FADE_STEP`.
- **Load while busy** (PENDING or FADING): the load is ignored. Targets are unchanged and no error is flagged. The decoder must wait for `busy=0`.
- **Load coincident with a boundary while IDLE:** targets are captured in that cycle. The boundary update uses the pre-load registers, which equal `act`, so it has no effect. The new targets apply at the following boundary.
- **Reset values (asynchronous):**
  - `pre`, `cnt`, all `act`, all `tgt` = 0;
  - state = IDLE;
  - `busy`, `period_start` = 0;
  - `pwm_r`, `pwm_g`, `pwm_b` = `ACTIVE_LOW`, i.e. LED off.
- **Reset mid-period or mid-fade:** all outputs go to their reset values immediately. The in-flight load is discarded.

## Timing
- All outputs are registered.
- `pwm_x` reflects the `cnt`/`act_x` values of the current cycle and is visible one `clk_div` cycle later.
- `period_start` is high for exactly one `clk_div` cycle: the cycle in which `cnt` first reads 0. This is aligned with the first `pwm_x` sample that uses the updated `act`.
- Period length is 255 × PRESCALE cycles. On-time is act × PRESCALE cycles, as one contiguous pulse starting at `period_start`.
- `busy` rises in the cycle after `load` is sampled.
- `busy` falls in the cycle after the boundary that makes `act == tgt`.
- Worst-case latency from `load` to first new-duty sample is 255 × PRESCALE + 1 cycles.
- A full fade takes ceil(max|Δ| / FADE_STEP) periods.
- First boundary after reset: `cnt` reads 0 on the first cycle after reset release but does not assert `period_start`. The first pulse comes at the first wrap.

## Test plan
- **Reset release, no load:** `pwm_*` stay at 0 (`ACTIVE_LOW=0`) for 2000 cycles. `period_start` pulses every 255 cycles. `busy=0`.
- **Immediate load:** PRESCALE=1, FADE_STEP=0, load R=128, G=0, B=255. `busy` stays high until the next wrap. After it, each period has `pwm_r` high 128 contiguous cycles, `pwm_g` never high, `pwm_b` high all 255 cycles.
- **Load while busy:** load R=10, then one cycle later load R=200 while `busy=1`. After the boundary `act_r=10`, seen as `pwm_r` high 10 cycles per period. The second load has no effect.
- **Fade:** FADE_STEP=64, from R=0 load R=255. Successive periods show `pwm_r` on-time 64, 128, 192, 255. `busy` drops after the 4th boundary. Then load R=0 from 255, expecting 191, 127, 63, 0.
- **Prescale and polarity:** PRESCALE=4, ACTIVE_LOW=1, load G=50. Period is 1020 cycles. `pwm_g` is low for 200 cycles and high for 820. `pwm_r`/`pwm_b` stay high.
- **Reset mid-fade:** assert `rst` mid-fade at `cnt=100`. All `pwm_*` go to their off level immediately and `busy=0`. After release, a subsequent load R=30 behaves as in the immediate-load case.
